// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the processor byte-input path.
//   io_state_t      - output handshake FSM states
//   IO_FIFO_DEPTH   - default input FIFO depth
//   IO_FIFO_THRESH  - default fill level for the interrupt request
package io_pkg;

  typedef enum logic [1:0] {
    IO_IDLE     = 2'd0,
    IO_PRESENT  = 2'd1,
    IO_WAIT_LOW = 2'd2
  } io_state_t;

  localparam int IO_FIFO_DEPTH  = 8;
  localparam int IO_FIFO_THRESH = 4;

endpackage

// File: rtl/io_fifo_mem.sv
// io_fifo_mem: DEPTH x 8 register array, synchronous write, asynchronous read.
// Ports:
//   clk    in      clock, rising edge
//   we     in      write enable
//   waddr  in  AW  write address
//   wdata  in  8   write data
//   raddr  in  AW  read address
//   rdata  out 8   read data (combinational from raddr)
module io_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_in_fifo.sv
// io_in_fifo: input-port buffer between a valid/ready byte producer and the
// processor's four-phase in/inDataReady/inACK handshake.
// Optional feature: define IO_IN_FIFO_INT_EN to build the fill-threshold
// interrupt request; otherwise int_req is tied low and THRESH is unused.
// Ports:
//   clk          in      clock, rising edge
//   reset        in      asynchronous active-low reset
//   wr_valid     in      producer has a byte
//   wr_data      in  8   producer byte
//   wr_ready     out     FIFO can accept (count != DEPTH)
//   flush        in      synchronous clear of FIFO contents
//   in           out 8   byte presented to processor (registered)
//   inDataReady  out     byte on in is valid (registered)
//   inACK        in      processor has latched in
//   count        out AW+1 current occupancy
//   int_req      out     level interrupt request, count >= THRESH (registered)
module io_in_fifo
  import io_pkg::*;
#(
  parameter int DEPTH  = IO_FIFO_DEPTH,
  parameter int AW     = 3,
  parameter int THRESH = IO_FIFO_THRESH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  input  logic        flush,
  output logic [7:0]  in,
  output logic        inDataReady,
  input  logic        inACK,
  output logic [AW:0] count,
  output logic        int_req
);

  if (DEPTH != (1 << AW) || DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("io_in_fifo: DEPTH must be 2**AW within 2..256");
  end
  if (THRESH < 1 || THRESH > DEPTH) begin : g_bad_thresh
    $error("io_in_fifo: THRESH must be within 1..DEPTH");
  end

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  io_state_t     state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [7:0]    rd_data;
  logic          push;
  logic          pop;

  // Full decision uses registered count only; a same-cycle pop does not help.
  assign wr_ready = (count != CNT_FULL);
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = (state == IO_PRESENT) && inACK;

  io_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (wr_data),
    .raddr (rptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IO_IDLE;
      in          <= '0;
      inDataReady <= 1'b0;
    end else begin
      case (state)
        IO_IDLE: begin
          if (count != '0 && !flush) begin
            in          <= rd_data;
            inDataReady <= 1'b1;
            state       <= IO_PRESENT;
          end
        end
        IO_PRESENT: begin
          // Flush without ack withdraws the byte but still waits for inACK low.
          if (inACK || flush) begin
            inDataReady <= 1'b0;
            state       <= IO_WAIT_LOW;
          end
        end
        IO_WAIT_LOW: begin
          if (!inACK) state <= IO_IDLE;
        end
        default: begin
          inDataReady <= 1'b0;
          state       <= IO_IDLE;
        end
      endcase
    end
  end

`ifdef IO_IN_FIFO_INT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) int_req <= 1'b0;
    else        int_req <= (count >= (AW+1)'(THRESH));
  end
`else
  assign int_req = 1'b0;
`endif

endmodule

// File: doc/io_in_fifo.md
# io_in_fifo

Input-port buffer upstream of the processor's byte-input handshake. It accepts bytes from an external producer over a valid/ready interface and stores them in a small FIFO. It presents them one at a time on the processor's `in`/`inDataReady`/`inACK` four-phase handshake. It can optionally raise a level interrupt request, wired to `int0`, when the FIFO reaches a fill threshold.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..256.
- `AW`, 3: pointer width, log2(DEPTH).
- `THRESH`, 4: fill level at which `int_req` asserts; range 1..DEPTH.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: producer has a byte.
- `wr_data` in 8: producer byte.
- `wr_ready` out 1: FIFO can accept; combinational `count != DEPTH`.
- `flush` in 1: synchronous clear of FIFO contents.
- `in` out 8: byte to processor; registered.
- `inDataReady` out 1: byte on `in` valid; registered.
- `inACK` in 1: processor has latched `in`.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `int_req` out 1: fill-threshold interrupt request, level.

## Operation
- Push: at a rising edge with `wr_valid && wr_ready`, write `wr_data` at `wptr`. `wptr` wraps modulo DEPTH.
- Full: when full, `wr_ready` is 0 and the producer holds its data. There is no drop path.
- A pop in the same cycle does not raise `wr_ready`; the full decision uses the registered `count`.
- Output FSM, states IDLE, PRESENT, WAIT_LOW:
  - IDLE: if `count > 0` and not `flush`: load `in <= mem[rptr]`, set `inDataReady <= 1`, go to PRESENT.
  - PRESENT: `in` is held stable.
    - If `inACK`: `inDataReady <= 0`, pop (`rptr+1`, `count-1`), go to WAIT_LOW.
    - If `flush` without `inACK`: `inDataReady <= 0`, no pop, go to WAIT_LOW.
  - WAIT_LOW: when `inACK == 0`, go to IDLE.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `flush`: at the edge, `wptr`, `rptr` and `count` go to 0, and a same-cycle push is discarded. The FSM behaves as above.
- `flush` during WAIT_LOW: the FSM stays in WAIT_LOW until `inACK` falls.
- `int_req` = `count >= THRESH`, registered. It deasserts as the processor drains the FIFO below THRESH.

## Timing
- Reset values:
  - state IDLE.
  - `in = 8'h00`, `inDataReady = 0`, `int_req = 0`.
  - `count = 0`, pointers 0.
  - `wr_ready = 1`.
- Reset mid-handshake: `inDataReady` drops immediately (asynchronously); the in-flight byte is lost.
- Latency:
  - Push accepted at edge N: `count = 1` after N; `inDataReady = 1` after edge N+1.
  - `inACK` high sampled at edge M: `inDataReady = 0` after M.
  - `inACK` low sampled at edge K in WAIT_LOW: IDLE after K. The next byte is presented after K+1.
- Throughput: at most one byte per 3 cycles plus processor acknowledge delay.
- `int_req`: follows `count` by one cycle.

## Configuration
- `IO_IN_FIFO_INT_EN` defined: `int_req` implemented as above.
- `IO_IN_FIFO_INT_EN` undefined:
  - `int_req` is tied to 0.
  - The threshold compare and register are not built.
  - THRESH is ignored.

## Structure
- Shared package `io_pkg`:
  - FSM state enum (`IO_IDLE`, `IO_PRESENT`, `IO_WAIT_LOW`).
  - Defaults `IO_FIFO_DEPTH = 8` and `IO_FIFO_THRESH = 4`.
- One sub-module, `io_fifo_mem`: DEPTH x 8 register array with synchronous write and asynchronous read at `rptr`.
- Pointers, count and FSM live in `io_in_fifo`.

## Test plan
- Single byte: push 8'hA5 and the processor acks after 2 cycles. `in = A5`, `inDataReady` high one cycle after the push, and `count` back to 0 after the ack.
- Fill: push 9 bytes 01..09 with no ack.
  - Bytes 01..08 are accepted and `count = 8`.
  - `wr_ready = 0`, and 09 is held until the first pop.
  - Then the output order is 01..09.
- Wrap-around: run 20 push/ack pairs with interleaved pushes. The output sequence equals the input sequence across pointer wrap.
- Threshold with macro defined: push 4 bytes, so `int_req = 1` one cycle after `count = 4`. Drain 1 byte, so `int_req = 0`.
- Threshold without macro: `int_req` stays 0 throughout.
- Flush mid-handshake:
  - Setup: 3 bytes queued, state PRESENT, `inACK` held low.
  - Assert `flush`: `count = 0` and `inDataReady = 0` next cycle.
  - No new byte is presented until a new push.
- Async reset: assert `reset` low while `inDataReady = 1`. Without waiting for a clock edge, `inDataReady = 0`, `in = 00` and `count = 0`.
